// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    // Instruction word presented alongside a misaligned-fetch fault.
    localparam logic [31:0] FAULT_INST       = 32'h0;

endpackage

// File: rtl/fetch_npc_sel.sv
// Next-PC selection: drives the PC register input every cycle.
module fetch_npc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  fetch_state_t state,
    input  logic         transfer,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic [31:0]  currentpc,
    output logic [31:0]  nextpc
);

    // Priority: reset vector, then redirect, then sequential advance, else hold.
    always_comb begin
        // NOTE: default assignment first so no path leaves nextpc unassigned (no latch).
        nextpc = currentpc;
        if (state == ST_IDLE) begin
            nextpc = RESET_PC;
        end else if (redirect_valid) begin
            nextpc = redirect_pc;
        end else if (transfer) begin
            nextpc = currentpc + PC_STEP;  // wraps modulo 2^32
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem read, single-entry output
// buffer to decode, and the nextpc feedback into the PC register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] currentpc,
    output logic [31:0] nextpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    fetch_state_t state;
    logic         drop;      // in-flight response belongs to a flushed path
    logic         misaligned;
    logic         transfer;

    assign misaligned = (currentpc[1:0] != 2'b00);
    assign imem_addr  = currentpc;
    // Reset forces state to IDLE asynchronously, so the request drops with it.
    assign imem_req   = (state == ST_REQ) && !misaligned && !redirect_valid;
    // A redirect flushes decode in the same cycle, so it cancels a handshake.
    assign transfer   = (state == ST_HOLD) && out_ready && !redirect_valid;

    fetch_npc_sel #(
        .RESET_PC (RESET_PC)
    ) u_npc_sel (
        .state          (state),
        .transfer       (transfer),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .currentpc      (currentpc),
        .nextpc         (nextpc)
    );

    // Fetch FSM plus the registered output buffer towards decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            state     <= ST_IDLE;
            drop      <= 1'b0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
            out_fault <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (!redirect_valid) begin
                        if (misaligned) begin
                            state     <= ST_HOLD;
                            out_valid <= 1'b1;
                            out_inst  <= FAULT_INST;
                            out_fault <= 1'b1;
                            out_pc    <= currentpc;
                        end else if (imem_gnt) begin
                            state  <= ST_WAIT;
                            out_pc <= currentpc;
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect_valid || drop) begin
                            // Stale response: discard and refetch from the current PC.
                            drop  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            state     <= ST_HOLD;
                            out_inst  <= imem_rdata;
                            out_fault <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a PC register, a zero-wait memory
// model and a manually driven memory for the multi-cycle corner cases.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] currentpc;
    logic [31:0] nextpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;

    // memory model controls
    logic        auto_mem;
    logic        man_gnt;
    logic        man_rvalid;
    logic [31:0] man_rdata;
    logic        pend_q;
    logic [31:0] pend_data;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .currentpc      (currentpc),
        .nextpc         (nextpc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory image used by the zero-wait model.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // PC register closing the loop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) currentpc <= 32'h0;
        else       currentpc <= nextpc;
    end

    // Zero-wait memory: grant in the request cycle, data the next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q    <= 1'b0;
            pend_data <= 32'h0;
        end else begin
            pend_q    <= imem_req && imem_gnt;
            pend_data <= mem_word(imem_addr);
        end
    end

    assign imem_gnt    = auto_mem ? imem_req  : man_gnt;
    assign imem_rvalid = auto_mem ? pend_q    : man_rvalid;
    assign imem_rdata  = auto_mem ? pend_data : man_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs[16];

    initial begin
        reset          = 1'b1;
        auto_mem       = 1'b1;
        man_gnt        = 1'b0;
        man_rvalid     = 1'b0;
        man_rdata      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Zero-wait stream, then a 5-cycle decode stall and release.
        //             rdy req addr          val pc            inst          nextpc
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h8002_0000};
        vecs[1]  = '{1'b1, 1'b1, 32'h8002_0000, 1'b0, 32'h0,         32'h0,         32'h8002_0000};
        vecs[2]  = '{1'b1, 1'b0, 32'h8002_0000, 1'b0, 32'h8002_0000, 32'h0,         32'h8002_0000};
        vecs[3]  = '{1'b1, 1'b0, 32'h8002_0000, 1'b1, 32'h8002_0000, 32'h25A7_0000, 32'h8002_0004};
        vecs[4]  = '{1'b1, 1'b1, 32'h8002_0004, 1'b0, 32'h8002_0000, 32'h0,         32'h8002_0004};
        vecs[5]  = '{1'b1, 1'b0, 32'h8002_0004, 1'b0, 32'h8002_0004, 32'h0,         32'h8002_0004};
        vecs[6]  = '{1'b1, 1'b0, 32'h8002_0004, 1'b1, 32'h8002_0004, 32'h25A7_0004, 32'h8002_0008};
        vecs[7]  = '{1'b1, 1'b1, 32'h8002_0008, 1'b0, 32'h8002_0004, 32'h0,         32'h8002_0008};
        vecs[8]  = '{1'b1, 1'b0, 32'h8002_0008, 1'b0, 32'h8002_0008, 32'h0,         32'h8002_0008};
        vecs[9]  = '{1'b0, 1'b0, 32'h8002_0008, 1'b1, 32'h8002_0008, 32'h25A7_0008, 32'h8002_0008};
        vecs[10] = '{1'b0, 1'b0, 32'h8002_0008, 1'b1, 32'h8002_0008, 32'h25A7_0008, 32'h8002_0008};
        vecs[11] = '{1'b0, 1'b0, 32'h8002_0008, 1'b1, 32'h8002_0008, 32'h25A7_0008, 32'h8002_0008};
        vecs[12] = '{1'b0, 1'b0, 32'h8002_0008, 1'b1, 32'h8002_0008, 32'h25A7_0008, 32'h8002_0008};
        vecs[13] = '{1'b0, 1'b0, 32'h8002_0008, 1'b1, 32'h8002_0008, 32'h25A7_0008, 32'h8002_0008};
        vecs[14] = '{1'b1, 1'b0, 32'h8002_0008, 1'b1, 32'h8002_0008, 32'h25A7_0008, 32'h8002_000C};
        vecs[15] = '{1'b1, 1'b1, 32'h8002_000C, 1'b0, 32'h8002_0008, 32'h0,         32'h8002_000C};

        // Reset-state outputs while reset is held.
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_imem_req",  {31'b0, imem_req},  32'h0);
        check("rst_out_pc",    out_pc,             32'h0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            out_ready = vecs[i].ready;
            @(negedge clock);
            check($sformatf("v%0d_req", i),   {31'b0, imem_req},  {31'b0, vecs[i].exp_req});
            check($sformatf("v%0d_addr", i),  imem_addr,          vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d_pc", i),    out_pc,             vecs[i].exp_pc);
            check($sformatf("v%0d_npc", i),   nextpc,             vecs[i].exp_npc);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_inst", i),  out_inst,           vecs[i].exp_inst);
                check($sformatf("v%0d_fault", i), {31'b0, out_fault}, 32'h0);
            end
            @(posedge clock);
            #1;
        end

        // Redirect during WAIT; the late response must be dropped.
        auto_mem  = 1'b0;
        out_ready = 1'b0;
        do_reset();
        cyc();                                  // IDLE -> REQ
        man_gnt = 1'b1;
        cyc();                                  // REQ -> WAIT
        man_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_1000;
        #1;
        check("wr_npc_redirect", nextpc, 32'h8002_1000);
        check("wr_req_off",      {31'b0, imem_req}, 32'h0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("wr_npc_hold", nextpc, 32'h8002_1000);
        cyc();
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        cyc();
        man_rvalid = 1'b0;
        #1;
        check("wr_no_valid", {31'b0, out_valid}, 32'h0);
        check("wr_refetch_req",  {31'b0, imem_req}, 32'h1);
        check("wr_refetch_addr", imem_addr, 32'h8002_1000);
        man_gnt = 1'b1;
        cyc();
        man_gnt    = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'h1234_5678;
        cyc();
        man_rvalid = 1'b0;
        #1;
        check("wr_valid",   {31'b0, out_valid}, 32'h1);
        check("wr_inst",    out_inst, 32'h1234_5678);
        check("wr_pc",      out_pc,   32'h8002_1000);

        // Redirect coincident with out_ready in HOLD: no transfer.
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8003_0000;
        #1;
        check("hr_npc", nextpc, 32'h8003_0000);
        cyc();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check("hr_valid_drop", {31'b0, out_valid}, 32'h0);
        check("hr_req",        {31'b0, imem_req},  32'h1);
        check("hr_addr",       imem_addr,          32'h8003_0000);

        // Redirect to a misaligned target produces a fault entry.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8002_0002;
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("mis_no_req", {31'b0, imem_req}, 32'h0);
        check("mis_npc",    nextpc,            32'h8002_0002);
        cyc();
        check("mis_valid", {31'b0, out_valid}, 32'h1);
        check("mis_fault", {31'b0, out_fault}, 32'h1);
        check("mis_inst",  out_inst,           32'h0);
        check("mis_pc",    out_pc,             32'h8002_0002);

        // Sequential step from the top of the address space wraps to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        man_gnt        = 1'b1;
        cyc();
        man_gnt    = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hCAFE_0001;
        cyc();
        man_rvalid = 1'b0;
        out_ready  = 1'b1;
        #1;
        check("wrap_pc",    out_pc,            32'hFFFF_FFFC);
        check("wrap_fault", {31'b0, out_fault}, 32'h0);
        check("wrap_npc",   nextpc,            32'h0);
        out_ready = 1'b0;

        // Reset asserted while in WAIT.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8004_0000;
        cyc();
        redirect_valid = 1'b0;
        man_gnt        = 1'b1;
        cyc();                                  // REQ -> WAIT, out_pc = 8004_0000
        man_gnt = 1'b0;
        reset   = 1'b1;
        #1;
        check("rw_valid", {31'b0, out_valid}, 32'h0);
        check("rw_req",   {31'b0, imem_req},  32'h0);
        check("rw_pc",    out_pc,             32'h0);
        check("rw_inst",  out_inst,           32'h0);
        check("rw_fault", {31'b0, out_fault}, 32'h0);
        check("rw_npc",   nextpc,             32'h8002_0000);
        cyc();
        reset = 1'b0;
        cyc();                                  // IDLE -> REQ
        check("rw_first_req",  {31'b0, imem_req}, 32'h1);
        check("rw_first_addr", imem_addr,         32'h8002_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly downstream of the program counter register and closing its feedback loop. Consumes currentpc, issues one instruction-memory read at a time over a req/gnt/rvalid handshake, and buffers the returned word for decode with a valid/ready handshake. Drives nextpc back into the PC register every cycle: hold, sequential +4, or redirect target. Handles redirect/flush, including discarding an in-flight response.

Parameters:
RESET_PC, 32'h8002_0000, value driven on nextpc while in IDLE; becomes the first fetched address.
PC_STEP, 4, byte increment per sequential instruction.

Ports:
clock  in  1  rising-edge clock, shared with the PC register
reset  in  1  asynchronous, active-high reset
currentpc  in  32  PC register output
nextpc  out  32  combinational; loaded by the PC register on every rising edge
imem_req  out  1  read request
imem_addr  out  32  read address; equals currentpc whenever imem_req=1
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid; at most one per granted request, earliest the cycle after gnt
imem_rdata  in  32  read data
redirect_valid  in  1  flush and redirect, single-cycle pulse
redirect_pc  in  32  redirect target
out_valid  out  1  instruction available to decode (registered)
out_ready  in  1  decode accepts
out_inst  out  32  instruction word
out_pc  out  32  address of out_inst
out_fault  out  1  misaligned-fetch marker, qualified by out_valid

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. Registered drop flag.
- Async reset: state=IDLE, drop=0, out_valid=0, out_inst=0, out_pc=0, out_fault=0. imem_req=0 while reset is asserted. Instruction memory shares this reset, so no stale response survives it.
- IDLE: nextpc=RESET_PC. Next edge -> REQ; the PC loads RESET_PC on the same edge.
- REQ, aligned (currentpc[1:0]==0):
  - imem_req = ~redirect_valid.
  - On gnt -> WAIT and capture out_pc<=currentpc.
  - nextpc=currentpc.
- REQ, misaligned:
  - No request issued.
  - Next edge -> HOLD with out_valid=1, out_inst=0, out_fault=1, out_pc=currentpc.
- WAIT: imem_req=0, nextpc=currentpc.
  - On rvalid with drop=0 -> HOLD with out_inst<=imem_rdata, out_fault<=0, out_valid<=1.
  - On rvalid with drop=1 -> REQ and clear drop; the data is discarded.
- HOLD: out_valid=1, outputs stable.
  - If out_ready: transfer. nextpc=currentpc+PC_STEP (mod 2^32, so 32'hFFFF_FFFC wraps to 0). Next edge -> REQ with out_valid<=0.
  - Otherwise nextpc=currentpc and state stays HOLD.
- Redirect (any state except IDLE) has priority over everything; nextpc=redirect_pc.
  - REQ: request suppressed that cycle; stay REQ.
  - WAIT: set drop; stay WAIT. If rvalid arrives in the same cycle, discard it and go to REQ with drop=0.
  - HOLD: out_valid<=0 -> REQ. A simultaneous out_ready is not a transfer; decode is flushed by the same pulse.
  - Repeated redirects while drop=1: nextpc follows the latest target; drop stays 1.
- Latency:
  - gnt in request cycle T; rvalid at T+1 earliest; out_valid at T+2.
  - Best-case throughput is one instruction per 3 cycles.
- Exactly one outstanding memory request at any time.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (IDLE/REQ/WAIT/HOLD);
  - RESET_PC_DEFAULT = 32'h8002_0000;
  - PC_STEP = 4;
  - FAULT_INST = 32'h0.
- One natural sub-module, fetch_npc_sel: combinational nextpc mux over (state, transfer, redirect_valid, redirect_pc, currentpc).
- The FSM and output registers stay in fetch_unit.

Test Plan:
- Reset release with a zero-wait memory (gnt in request cycle, rvalid next cycle), out_ready=1 -> imem_addr sequence 8002_0000, 8002_0004, 8002_0008; out_pc/out_inst match the memory image; out_valid every 3rd cycle.
- out_ready held 0 for 5 cycles after out_valid -> out_inst/out_pc stable, nextpc==currentpc, no imem_req; on release the next address is +4.
- Redirect to 8002_1000 while in WAIT, rvalid 2 cycles later with 32'hDEADBEEF -> word never appears on out_inst; next imem_addr=8002_1000.
- Redirect coincident with out_ready in HOLD -> no transfer counted; out_valid drops; next fetch is redirect_pc, not +4.
- Redirect to 8002_0002 -> no imem_req; out_valid=1, out_fault=1, out_inst=0, out_pc=8002_0002.
- Assert reset while in WAIT -> all outputs return to reset values immediately; after release, first imem_addr=8002_0000.
